// File: rtl/hc_sr04_emulator.sv
// HC-SR04 responder model: answers a trigger pulse with an echo
// whose width encodes range_cm, then enforces a holdoff period.
module hc_sr04_emulator #(
  parameter int unsigned TRIG_MIN_CYCLES     = 500,
  parameter int unsigned BURST_CYCLES        = 10000,
  parameter int unsigned CYCLES_PER_CM       = 2941,
  parameter int unsigned MIN_RANGE_CM        = 2,
  parameter int unsigned MAX_RANGE_CM        = 400,
  parameter int unsigned ECHO_TIMEOUT_CYCLES = 1900000,
  parameter int unsigned HOLDOFF_CYCLES      = 500000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       trigger,
  input  logic [8:0] range_cm,
  output logic       echo,
  output logic       busy,
  output logic       short_trig
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG_HIGH,
    S_BURST,
    S_ECHO,
    S_HOLDOFF
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, trig_s_q, trig_prev_q;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] width_q, width_d;
  logic [8:0]  range_q, range_d;
  logic        echo_q, echo_d;
  logic        busy_q, busy_d;
  logic        short_q, short_d;

  logic        rise, fall;
  logic [31:0] r32;
  logic [31:0] prod;

  assign rise = trig_s_q & ~trig_prev_q;
  assign fall = ~trig_s_q & trig_prev_q;
  assign r32  = {23'd0, range_q};
  assign prod = r32 * CYCLES_PER_CM;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b0;
      trig_s_q    <= 1'b0;
      trig_prev_q <= 1'b0;
      cnt_q       <= '0;
      width_q     <= '0;
      range_q     <= '0;
      echo_q      <= 1'b0;
      busy_q      <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= trigger;
      trig_s_q    <= sync1_q;
      trig_prev_q <= trig_s_q;
      cnt_q       <= cnt_d;
      width_q     <= width_d;
      range_q     <= range_d;
      echo_q      <= echo_d;
      busy_q      <= busy_d;
      short_q     <= short_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    width_d = width_q;
    range_d = range_q;
    short_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // the rise cycle itself counts as the first high cycle
        if (rise) begin
          state_d = S_TRIG_HIGH;
          cnt_d   = 32'd1;
        end
      end
      S_TRIG_HIGH: begin
        if (fall) begin
          cnt_d = '0;
          if (cnt_q >= TRIG_MIN_CYCLES) begin
            range_d = range_cm;
            state_d = S_BURST;
          end else begin
            short_d = 1'b1;
            state_d = S_IDLE;
          end
        end else if (trig_s_q && cnt_q < TRIG_MIN_CYCLES) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_BURST: begin
        if (r32 < MIN_RANGE_CM)
          width_d = MIN_RANGE_CM * CYCLES_PER_CM;
        else if (r32 > MAX_RANGE_CM)
          width_d = ECHO_TIMEOUT_CYCLES;
        else
          width_d = prod;
        if (cnt_q == BURST_CYCLES - 1) begin
          cnt_d   = '0;
          state_d = S_ECHO;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_ECHO: begin
        if (cnt_q == width_q - 32'd1) begin
          cnt_d   = '0;
          state_d = S_HOLDOFF;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_HOLDOFF: begin
        if (cnt_q == HOLDOFF_CYCLES - 1) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    echo_d = (state_d == S_ECHO);
    busy_d = (state_d == S_BURST) ||
             (state_d == S_ECHO) ||
             (state_d == S_HOLDOFF);
  end

  assign echo       = echo_q;
  assign busy       = busy_q;
  assign short_trig = short_q;

endmodule
